mbv_result_collector: RTL and testbench
=======================================

// Module: mbv_result_collector
// PURPOSE
//  Downstream stage of the matrix-by-vector unit: captures each NI-element result word the
//  decoder presents on its read_now strobe, buffers it in a small FIFO, and writes it to the
//  result vector memory at sequential addresses under memory backpressure. Counts words against
//  the expected total and raises done when the full result vector has been committed.
// PARAMETERS
//  element_width   32  bits per vector element
//  NI               8  elements per result word (matches decoder output width NI*element_width)
//  FIFO_DEPTH       4  result-word buffer depth, power of 2, >=2
//  ADDR_WIDTH      10  result memory word-address width
// PORTS
//  clk            in   1                 rising-edge clock
//  reset          in   1                 asynchronous, active-high reset
//  start          in   1                 level; high for the whole operation, low clears block
//  total_rows     in   32                number of result elements expected (rows of A)
//  base_addr      in   ADDR_WIDTH        first memory word address, sampled on start rise
//  in_data        in   NI*element_width  decoder result word
//  in_valid       in   1                 decoder read_now strobe; one pulse = one word
//  mem_ready      in   1                 memory accepts a write this cycle
//  mem_wr_en      out  1                 write strobe
//  mem_addr       out  ADDR_WIDTH        write word address
//  mem_wr_data    out  NI*element_width  write data
//  words_written  out  32                words committed so far
//  overflow       out  1                 sticky: word arrived while FIFO full (word dropped)
//  done           out  1                 all expected words committed
// BEHAVIOUR
//  - Reset (async): state=IDLE, FIFO empty, all outputs 0.
//  - expected = ceil(total_rows/NI) = (total_rows+NI-1)/NI, computed in 33 bits, latched on
//    IDLE->COLLECT; total_rows changes mid-operation are ignored.
//  - FSM: IDLE -> COLLECT when start=1 (latch base_addr, expected; clear counters, overflow).
//    COLLECT -> DRAIN when accepted-word count reaches expected. DRAIN -> DONE when FIFO empty
//    and words_written==expected. DONE holds done=1 until start=0. Any state -> IDLE when
//    start=0 (FIFO flushed, counters cleared, done=0, overflow cleared).
//  - expected==0: COLLECT -> DONE next cycle, no writes.
//  - Capture: in COLLECT, in_valid=1 and FIFO not full -> push in_data. FIFO full -> drop, set
//    overflow (sticky until IDLE). in_valid in IDLE/DRAIN/DONE ignored (no push, no overflow).
//  - Simultaneous push and pop on a full FIFO: pop takes effect first, push accepted.
//  - Write port: mem_wr_en is registered; asserted when FIFO non-empty, mem_wr_data = head.
//    Transfer occurs on a cycle with mem_wr_en=1 and mem_ready=1: pop, mem_addr+1 (wraps mod
//    2^ADDR_WIDTH), words_written+1. mem_wr_en/mem_addr/mem_wr_data stay stable while
//    mem_ready=0.
//  - Latency: in_valid at cycle t, FIFO empty, mem_ready=1 -> mem_wr_en=1 at t+1 with that word,
//    committed at t+1. Sustained throughput 1 word/cycle.
//  - done rises the cycle after the final transfer; mem_wr_en=0 in DONE.
//  - Reset mid-operation: immediate return to reset values; partial writes are not undone.
// STRUCTURE
//  - Shared package mbv_pkg: state encoding (IDLE, COLLECT, DRAIN, DONE), ceil-div helper
//    function, default element_width/NI constants shared with the matrix-by-vector unit.
//  - One sub-module: mbv_result_fifo (parameterised width/depth, async reset, synchronous
//    flush, full/empty flags, pointer-wrap with extra MSB). Top holds FSM, counters, write port.
// TESTING
//  1 total_rows=16, NI=8, base_addr=0x10, two in_valid pulses, mem_ready=1 -> writes at 0x10,
//    0x11 with matching data, words_written=2, done=1 one cycle after second write.
//  2 total_rows=17 -> expected=3; three pulses -> 3 writes, done; a 4th pulse is ignored.
//  3 mem_ready=0 for 10 cycles, 6 pulses, FIFO_DEPTH=4 -> 4 buffered, overflow=1, then
//    mem_ready=1 -> 4 writes in order, never done (expected 6 not reached).
//  4 base_addr=2^ADDR_WIDTH-1, 2 words -> addresses wrap to max then 0.
//  5 start dropped in DRAIN with 2 words queued -> next cycle FIFO empty, mem_wr_en=0, done=0,
//    words_written=0; restart works with fresh counts.
//  6 reset asserted asynchronously mid-COLLECT -> outputs 0 without a clock edge; total_rows=0
//    run -> done next cycle after start, zero writes.

Source files
------------

// File: rtl/mbv_pkg.sv
// Shared definitions for the matrix-by-vector unit.
//   - DefaultElementWidth / DefaultNi : element size and elements per word
//   - mbv_state_e                     : result-collector FSM encoding
//   - ceil_div()                      : 33-bit ceiling division used for word counts
package mbv_pkg;

   localparam int unsigned DefaultElementWidth = 32;
   localparam int unsigned DefaultNi           = 8;

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StDrain,
      StDone
   } mbv_state_e;

   // Widened to 33 bits so total_rows near 2^32 cannot overflow the rounding add.
   function automatic logic [32:0] ceil_div(input logic [31:0] num, input int unsigned den);
      logic [32:0] sum;
      sum = {1'b0, num} + 33'(den) - 33'd1;
      return sum / 33'(den);
   endfunction

endpackage

// File: rtl/mbv_result_fifo.sv
// Result-word FIFO with extra-MSB pointers.
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             synchronous clear of both pointers (has priority)
//   push_i, data_i      write request / data (ignored when full unless popping)
//   pop_i               read request (ignored when empty)
//   data_o              head word
//   full_o, empty_o     flags
//   count_o             current occupancy
module mbv_result_fifo #(
   parameter int unsigned Width = 256,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [Width-1:0]         data_i,
   input  logic                     pop_i,
   output logic [Width-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned Aw = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [Aw:0]      wptr_q, rptr_q;
   logic             push_ok, pop_ok;

   assign count_o = wptr_q - rptr_q;
   assign full_o  = (count_o == (Aw+1)'(Depth));
   assign empty_o = (wptr_q == rptr_q);
   assign data_o  = mem_q[rptr_q[Aw-1:0]];

   // A pop frees the head slot in the same cycle, so a full FIFO can still accept a push.
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else if (flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) mem_q[wptr_q[Aw-1:0]] <= data_i;
   end

endmodule

// File: rtl/mbv_result_collector.sv
// Collects decoder result words, buffers them and writes them to result memory at
// sequential addresses; raises done once the full result vector has been committed.
//   clk_i, reset_i        clock, asynchronous active-high reset
//   start_i               level; low returns the block to idle and flushes it
//   total_rows_i          result elements expected (latched on start)
//   base_addr_i           first write address (latched on start)
//   in_data_i, in_valid_i decoder result word and its one-cycle strobe
//   mem_ready_i           memory accepts the current write
//   mem_wr_en_o, mem_addr_o, mem_wr_data_o   write port
//   words_written_o       words committed so far
//   overflow_o            sticky: a word was dropped because the FIFO was full
//   done_o                all expected words committed
module mbv_result_collector
   import mbv_pkg::*;
#(
   parameter int unsigned ElementWidth = DefaultElementWidth,
   parameter int unsigned Ni           = DefaultNi,
   parameter int unsigned FifoDepth    = 4,
   parameter int unsigned AddrWidth    = 10
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       start_i,
   input  logic [31:0]                total_rows_i,
   input  logic [AddrWidth-1:0]       base_addr_i,
   input  logic [Ni*ElementWidth-1:0] in_data_i,
   input  logic                       in_valid_i,
   input  logic                       mem_ready_i,
   output logic                       mem_wr_en_o,
   output logic [AddrWidth-1:0]       mem_addr_o,
   output logic [Ni*ElementWidth-1:0] mem_wr_data_o,
   output logic [31:0]                words_written_o,
   output logic                       overflow_o,
   output logic                       done_o
);

   localparam int unsigned Dw = Ni * ElementWidth;
   localparam int unsigned Cw = $clog2(FifoDepth) + 1;

   mbv_state_e           state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [32:0]          expected_q, expected_d;
   logic [32:0]          accepted_q, accepted_d;
   logic [31:0]          written_q, written_d;
   logic                 overflow_q, overflow_d;

   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [Dw-1:0] fifo_head;
   logic [Cw-1:0] fifo_count, count_next;
   logic          wr_en, fire, collecting;

   mbv_result_fifo #(
      .Width (Dw),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (reset_i),
      .flush_i (!start_i),
      .push_i  (fifo_push),
      .data_i  (in_data_i),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Write strobe is decoded purely from flops (state and FIFO pointers), so it is
   // stable for the whole cycle and holds while mem_ready_i is low.
   assign wr_en      = !fifo_empty && (state_q == StCollect || state_q == StDrain);
   assign fire       = wr_en && mem_ready_i;
   assign fifo_pop   = fire;
   assign collecting = (state_q == StCollect) && start_i;
   assign fifo_push  = collecting && in_valid_i && (!fifo_full || fire);
   assign count_next = fifo_count + Cw'(fifo_push) - Cw'(fifo_pop);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      expected_d = expected_q;
      accepted_d = accepted_q;
      written_d  = written_q;
      overflow_d = overflow_q;

      if (fire) begin
         addr_d    = addr_q + 1'b1;
         written_d = written_q + 32'd1;
      end
      if (fifo_push) accepted_d = accepted_q + 33'd1;
      if (collecting && in_valid_i && !fifo_push) overflow_d = 1'b1;

      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d    = StCollect;
               addr_d     = base_addr_i;
               expected_d = ceil_div(total_rows_i, Ni);
               accepted_d = '0;
               written_d  = '0;
               overflow_d = 1'b0;
            end
         end
         StCollect: begin
            if (expected_q == 33'd0)           state_d = StDone;
            else if (accepted_d == expected_q) state_d = StDrain;
         end
         StDrain: begin
            if (count_next == '0 && {1'b0, written_d} == expected_q) state_d = StDone;
         end
         StDone: ;
         default: state_d = StIdle;
      endcase

      if (!start_i) begin
         state_d    = StIdle;
         addr_d     = '0;
         expected_d = '0;
         accepted_d = '0;
         written_d  = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         expected_q <= '0;
         accepted_q <= '0;
         written_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         expected_q <= expected_d;
         accepted_q <= accepted_d;
         written_q  <= written_d;
         overflow_q <= overflow_d;
      end
   end

   assign mem_wr_en_o     = wr_en;
   assign mem_addr_o      = addr_q;
   // FIFO storage is not reset, so gate the data to keep it zero when idle.
   assign mem_wr_data_o   = wr_en ? fifo_head : '0;
   assign words_written_o = written_q;
   assign overflow_o      = overflow_q;
   assign done_o          = (state_q == StDone);

endmodule

// File: tb/tb_mbv_result_collector.sv
module tb_mbv_result_collector;

   localparam int unsigned Aw = 10;
   localparam int unsigned Dw = 256;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [31:0]   total_rows;
   logic [Aw-1:0] base_addr;
   logic [Dw-1:0] in_data;
   logic          in_valid;
   logic          mem_ready;
   logic          mem_wr_en;
   logic [Aw-1:0] mem_addr;
   logic [Dw-1:0] mem_wr_data;
   logic [31:0]   words_written;
   logic          overflow;
   logic          done;

   typedef struct {
      logic [Aw-1:0] addr;
      logic [Dw-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   mbv_result_collector #(
      .ElementWidth (32),
      .Ni           (8),
      .FifoDepth    (4),
      .AddrWidth    (Aw)
   ) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .start_i         (start),
      .total_rows_i    (total_rows),
      .base_addr_i     (base_addr),
      .in_data_i       (in_data),
      .in_valid_i      (in_valid),
      .mem_ready_i     (mem_ready),
      .mem_wr_en_o     (mem_wr_en),
      .mem_addr_o      (mem_addr),
      .mem_wr_data_o   (mem_wr_data),
      .words_written_o (words_written),
      .overflow_o      (overflow),
      .done_o          (done)
   );

   always #5 clk = ~clk;

   function automatic logic [Dw-1:0] mk_word(int k);
      logic [Dw-1:0] w;
      for (int j = 0; j < 8; j++) w[j*32 +: 32] = 32'(k * 256 + j + 1) ^ 32'hA5A5_0000;
      return w;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_write(logic [Aw-1:0] a, int k);
      exp_t e;
      e.addr = a;
      e.data = mk_word(k);
      sb.push_back(e);
   endtask

   task automatic send_word(int k);
      in_valid = 1'b1;
      in_data  = mk_word(k);
      tick();
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic start_op(logic [31:0] rows, logic [Aw-1:0] base);
      start = 1'b0;
      tick();
      total_rows = rows;
      base_addr  = base;
      start      = 1'b1;
      tick();
   endtask

   task automatic wait_done(string name);
      for (int i = 0; i < 20 && !done; i++) tick();
      check(name, 64'(done), 64'd1);
   endtask

   // Monitor: every accepted write must match the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && mem_wr_en && mem_ready) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: got addr %0h, expected no write", mem_addr);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("write_addr", 64'(mem_addr), 64'(e.addr));
               vectors++;
               if (mem_wr_data !== e.data) begin
                  miscompares++;
                  $display("FAIL write_data: got %h, expected %h", mem_wr_data, e.data);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; total_rows = '0; base_addr = '0;
      in_data = '0; in_valid = 1'b0; mem_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_wr_en", 64'(mem_wr_en), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_words", 64'(words_written), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);

      // 1: two words, done the cycle after the second write
      start_op(32'd16, 10'h010);
      expect_write(10'h010, 0);
      expect_write(10'h011, 1);
      send_word(0);
      send_word(1);
      check("t1_second_write_pending", 64'(mem_wr_en), 64'd1);
      check("t1_done_early", 64'(done), 64'd0);
      tick();
      check("t1_done", 64'(done), 64'd1);
      check("t1_words", 64'(words_written), 64'd2);
      check("t1_wr_en_done", 64'(mem_wr_en), 64'd0);

      // 2: 17 rows -> 3 words; a 4th pulse in DRAIN is ignored
      start_op(32'd17, 10'h020);
      for (int k = 0; k < 3; k++) expect_write(10'h020 + 10'(k), 10 + k);
      for (int k = 0; k < 3; k++) send_word(10 + k);
      send_word(99);
      check("t2_done", 64'(done), 64'd1);
      tick(); tick(); tick();
      check("t2_words", 64'(words_written), 64'd3);
      check("t2_overflow", 64'(overflow), 64'd0);

      // 3: backpressure, 6 pulses into a 4-deep FIFO
      mem_ready = 1'b0;
      start_op(32'd48, 10'h030);
      for (int k = 0; k < 4; k++) expect_write(10'h030 + 10'(k), 20 + k);
      for (int k = 0; k < 6; k++) send_word(20 + k);
      for (int i = 0; i < 4; i++) tick();
      check("t3_overflow", 64'(overflow), 64'd1);
      check("t3_words_stalled", 64'(words_written), 64'd0);
      check("t3_addr_stalled", 64'(mem_addr), 64'h030);
      mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("t3_words", 64'(words_written), 64'd4);
      check("t3_not_done", 64'(done), 64'd0);
      check("t3_wr_en_idle", 64'(mem_wr_en), 64'd0);
      check("t3_overflow_sticky", 64'(overflow), 64'd1);

      // 4: address wrap
      start_op(32'd16, 10'h3FF);
      check("t4_overflow_cleared", 64'(overflow), 64'd0);
      expect_write(10'h3FF, 30);
      expect_write(10'h000, 31);
      send_word(30);
      send_word(31);
      wait_done("t4_done");
      check("t4_words", 64'(words_written), 64'd2);

      // 5: drop start in DRAIN with two words queued, then restart
      mem_ready = 1'b0;
      start_op(32'd16, 10'h040);
      send_word(40);
      send_word(41);
      check("t5_pending", 64'(mem_wr_en), 64'd1);
      start = 1'b0;
      tick();
      check("t5_wr_en", 64'(mem_wr_en), 64'd0);
      check("t5_done", 64'(done), 64'd0);
      check("t5_words", 64'(words_written), 64'd0);
      mem_ready = 1'b1;
      start_op(32'd8, 10'h050);
      expect_write(10'h050, 50);
      send_word(50);
      wait_done("t5_restart_done");
      check("t5_restart_words", 64'(words_written), 64'd1);

      // 6: asynchronous reset mid-COLLECT, then a zero-row run
      start_op(32'd64, 10'h060);
      for (int k = 0; k < 3; k++) expect_write(10'h060 + 10'(k), 60 + k);
      for (int k = 0; k < 3; k++) send_word(60 + k);
      check("t6_words_before", 64'(words_written), 64'd2);
      reset = 1'b1;
      #1;
      check("t6_async_wr_en", 64'(mem_wr_en), 64'd0);
      check("t6_async_words", 64'(words_written), 64'd0);
      check("t6_async_addr", 64'(mem_addr), 64'd0);
      check("t6_async_data", 64'(mem_wr_data != '0), 64'd0);
      check("t6_async_done", 64'(done), 64'd0);
      sb.delete();
      start = 1'b0;
      tick();
      reset = 1'b0;
      start_op(32'd0, 10'h070);
      tick();
      check("t6_zero_done", 64'(done), 64'd1);
      check("t6_zero_words", 64'(words_written), 64'd0);
      tick();
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
